// File: rtl/wb_block_copier_if.sv
// Wishbone classic master bundle driven by the block copier.
// Signal directions are named from the master's point of view.
interface wb_block_copier_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        ack;
  logic        err;
  logic        rty;

  modport master (
    output cyc, stb, we, adr, sel, dat_o,
    input  dat_i, ack, err, rty
  );

  modport slave (
    input  cyc, stb, we, adr, sel, dat_o,
    output dat_i, ack, err, rty
  );
endinterface

// File: rtl/wb_block_copier.sv
// Wishbone master that copies a block of 32-bit words from src to dst,
// one read/write pair per word, with retry, error and timeout handling.
module wb_block_copier #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned LEN_W   = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [31:0]       src_adr_i,
  input  logic [31:0]       dst_adr_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  wb_block_copier_if.master wbm
);

  localparam int unsigned TMO_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    FIN   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               cyc_q,   cyc_d;
  logic               stb_q,   stb_d;
  logic               we_q,    we_d;
  logic [3:0]         sel_q,   sel_d;
  logic [31:0]        adr_q,   adr_d;
  logic [31:0]        dat_q,   dat_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;
  logic               error_q, error_d;
  logic [31:0]        src_q,   src_d;
  logic [31:0]        dst_q,   dst_d;
  logic [LEN_W-1:0]   len_q,   len_d;
  logic [LEN_W-1:0]   cnt_q,   cnt_d;
  logic [TMO_W-1:0]   tmo_q,   tmo_d;

  logic [31:0]        word_off_c;
  logic [TMO_W-1:0]   tmo_inc_c;
  logic               last_word_c;

  // Byte offset of the current word; address sums wrap modulo 2^32.
  assign word_off_c  = 32'({cnt_q, 2'b00});
  assign tmo_inc_c   = TMO_W'(tmo_q + TMO_W'(1));
  assign last_word_c = (LEN_W'(cnt_q + LEN_W'(1)) == len_q);

  // Next-state and registered-output logic; stb defaults low so every
  // termination is followed by a one-cycle strobe gap.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    stb_d   = 1'b0;
    we_d    = 1'b0;
    adr_d   = adr_q;
    dat_d   = dat_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    error_d = error_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          src_d   = src_adr_i & ~32'h3;
          dst_d   = dst_adr_i & ~32'h3;
          len_d   = len_i;
          cnt_d   = '0;
          tmo_d   = '0;
          error_d = 1'b0;
          if (len_i != '0) begin
            state_d = READ;
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            busy_d  = 1'b1;
            adr_d   = src_adr_i & ~32'h3;
          end else begin
            state_d = FIN;
            done_d  = 1'b1;
          end
        end
      end

      READ, WRITE: begin
        if (!stb_q) begin
          // Gap cycle: (re)issue the access for the current word.
          stb_d = 1'b1;
          we_d  = (state_q == WRITE);
          adr_d = ((state_q == WRITE) ? dst_q : src_q) + word_off_c;
          tmo_d = '0;
        end else if (wbm.err) begin
          state_d = FIN;
          cyc_d   = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          error_d = 1'b1;
        end else if (wbm.ack) begin
          if (state_q == READ) begin
            dat_d   = wbm.dat_i;
            state_d = WRITE;
          end else begin
            cnt_d = LEN_W'(cnt_q + LEN_W'(1));
            if (last_word_c) begin
              state_d = FIN;
              cyc_d   = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              state_d = READ;
            end
          end
        end else if (!wbm.rty) begin
          if (tmo_inc_c == TMO_MAX) begin
            state_d = FIN;
            cyc_d   = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            error_d = 1'b1;
          end else begin
            stb_d = 1'b1;
            we_d  = we_q;
            tmo_d = tmo_inc_c;
          end
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign sel_d = stb_d ? 4'hF : 4'h0;

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= 4'h0;
      adr_q   <= '0;
      dat_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  assign wbm.cyc   = cyc_q;
  assign wbm.stb   = stb_q;
  assign wbm.we    = we_q;
  assign wbm.sel   = sel_q;
  assign wbm.adr   = adr_q;
  assign wbm.dat_o = dat_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign error_o   = error_q;

endmodule

// File: tb/tb_wb_block_copier.sv
// Bench for wb_block_copier: randomized copies against a word-level copy model,
// with a Wishbone slave that can wait, retry, error or stay silent.
module tb_wb_block_copier;

  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned LEN_W   = 12;

  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [31:0] dat;
  } acc_t;

  logic             clk;
  logic             rst;
  logic             start_i;
  logic [31:0]      src_adr_i;
  logic [31:0]      dst_adr_i;
  logic [LEN_W-1:0] len_i;
  logic             busy_o;
  logic             done_o;
  logic             error_o;

  wb_block_copier_if bus ();

  wb_block_copier #(
    .TIMEOUT (TIMEOUT),
    .LEN_W   (LEN_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .src_adr_i (src_adr_i),
    .dst_adr_i (dst_adr_i),
    .len_i     (len_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .error_o   (error_o),
    .wbm       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem     [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  acc_t        exp_q [$];

  int   err_at_s = -1;
  int   rty_at_s = -1;
  int   wait_fix = -1;
  bit   silent_s = 1'b0;
  int   acc_n = 0, done_cnt = 0, cyc_cnt = 0, stb_hi = 0, rty_seen = 0;
  int   wcnt = 0, wait_cur = 1;
  bit   term_prev = 1'b0, stb_prev = 1'b0, rty_pend = 1'b0;
  logic [31:0] rty_adr = '0, rty_dat = '0;

  int   cur_len = 0, cur_rty = -1;
  bit   cur_silent = 1'b0, cur_exp_err = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] slv_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  // Slave model and bus monitor, acting on the falling edge.
  always @(negedge clk) begin
    acc_t e;
    if (!rst) begin
      bus.ack   = 1'b0;
      bus.err   = 1'b0;
      bus.rty   = 1'b0;
      bus.dat_i = '0;
      term_prev = 1'b0;
      stb_prev  = 1'b0;
      rty_pend  = 1'b0;
      wcnt      = 0;
    end else begin
      if (done_o)  done_cnt++;
      if (bus.cyc) cyc_cnt++;
      if (bus.stb) stb_hi++;
      if (term_prev) check_eq("stb_gap", 32'(bus.stb), 32'd0);
      if (bus.stb && !stb_prev) begin
        check_eq("sel", 32'(bus.sel), 32'hF);
        check_eq("cyc_with_stb", 32'(bus.cyc), 32'd1);
        if (rty_pend) begin
          check_eq("rty_adr", bus.adr, rty_adr);
          if (bus.we) check_eq("rty_dat", bus.dat_o, rty_dat);
          rty_pend = 1'b0;
          rty_seen++;
        end
      end
      bus.ack   = 1'b0;
      bus.err   = 1'b0;
      bus.rty   = 1'b0;
      term_prev = 1'b0;
      if (bus.cyc && bus.stb && !silent_s) begin
        if (wcnt < wait_cur) begin
          wcnt++;
        end else begin
          wcnt      = 0;
          wait_cur  = (wait_fix >= 0) ? wait_fix : int'($urandom_range(0, 3));
          term_prev = 1'b1;
          if (acc_n == err_at_s) begin
            bus.err = 1'b1;
            bus.ack = 1'b1;
            acc_n++;
          end else if (acc_n == rty_at_s) begin
            bus.rty  = 1'b1;
            rty_at_s = -1;
            rty_pend = 1'b1;
            rty_adr  = bus.adr;
            rty_dat  = bus.dat_o;
          end else begin
            bus.ack = 1'b1;
            bus.rty = (acc_n % 2 == 0);
            acc_n++;
            if (bus.we) mem[bus.adr] = bus.dat_o;
            else        bus.dat_i    = slv_rd(bus.adr);
            check_eq("acc_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              check_eq("acc_we",  32'(bus.we), 32'(e.we));
              check_eq("acc_adr", bus.adr, e.adr);
              check_eq("acc_dat", bus.we ? bus.dat_o : bus.dat_i, e.dat);
            end
          end
        end
      end
      stb_prev = bus.stb;
    end
  end

  // Word-level copy model: expected acked accesses up to any error point.
  task automatic start_copy(input logic [31:0] src, input logic [31:0] dst, input int len,
                            input int err_at, input int rty_at, input bit silent_m);
    logic [31:0] s, d, v, a;
    acc_t e;
    s = src & ~32'h3;
    d = dst & ~32'h3;
    exp_q.delete();
    for (int i = 0; i < len; i++) begin
      if (silent_m || (err_at >= 0 && 2 * i >= err_at)) break;
      a = s + 32'(4 * i);
      v = ref_rd(a);
      e.we = 1'b0; e.adr = a; e.dat = v;
      exp_q.push_back(e);
      if (err_at >= 0 && 2 * i + 1 >= err_at) break;
      a = d + 32'(4 * i);
      e.we = 1'b1; e.adr = a; e.dat = v;
      exp_q.push_back(e);
      ref_mem[a] = v;
    end
    cur_len     = len;
    cur_rty     = rty_at;
    cur_silent  = silent_m;
    cur_exp_err = (len != 0) && (silent_m || (err_at >= 0 && err_at < 2 * len));
    err_at_s = err_at;
    rty_at_s = rty_at;
    silent_s = silent_m;
    acc_n = 0; done_cnt = 0; cyc_cnt = 0; stb_hi = 0; rty_seen = 0;
    start_i   = 1'b1;
    src_adr_i = src;
    dst_adr_i = dst;
    len_i     = LEN_W'(len);
  endtask

  task automatic finish_copy();
    int cycles;
    cycles = 0;
    @(negedge clk);
    start_i = 1'b0;
    check_eq("busy_after_start", 32'(busy_o), 32'(cur_len != 0));
    check_eq("error_cleared", 32'(error_o), 32'd0);
    while (!done_o && cycles < 3000) begin
      @(negedge clk);
      cycles++;
      start_i = 1'b0;
      if (!done_o && $urandom_range(0, 7) == 0) begin
        start_i   = 1'b1;
        src_adr_i = $urandom;
        dst_adr_i = $urandom;
        len_i     = LEN_W'($urandom);
      end
    end
    start_i = 1'b0;
    check_eq("done_seen", 32'(done_o), 32'd1);
    if (cur_len == 0) check_eq("len0_latency_ok", 32'(cycles <= 1), 32'd1);
    repeat (3) @(negedge clk);
    check_eq("done_once", 32'(done_cnt), 32'd1);
    check_eq("error", 32'(error_o), 32'(cur_exp_err));
    check_eq("exp_left", 32'(exp_q.size()), 32'd0);
    check_eq("cyc_idle", 32'(bus.cyc), 32'd0);
    check_eq("busy_idle", 32'(busy_o), 32'd0);
    if (cur_len == 0) check_eq("len0_cyc", 32'(cyc_cnt), 32'd0);
    if (cur_silent)   check_eq("timeout_stb", 32'(stb_hi), 32'(TIMEOUT));
    if (cur_rty >= 0) check_eq("rty_reissued", 32'(rty_seen), 32'd1);
  endtask

  task automatic run_copy(input logic [31:0] src, input logic [31:0] dst, input int len,
                          input int err_at, input int rty_at, input bit silent_m);
    start_copy(src, dst, len, err_at, rty_at, silent_m);
    finish_copy();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cycles;
    rst = 1'b0; start_i = 1'b0; src_adr_i = '0; dst_adr_i = '0; len_i = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_cyc",   32'(bus.cyc), 32'd0);
    check_eq("rst_stb",   32'(bus.stb), 32'd0);
    check_eq("rst_we",    32'(bus.we),  32'd0);
    check_eq("rst_sel",   32'(bus.sel), 32'd0);
    check_eq("rst_adr",   bus.adr,      32'd0);
    check_eq("rst_dat",   bus.dat_o,    32'd0);
    check_eq("rst_busy",  32'(busy_o),  32'd0);
    check_eq("rst_done",  32'(done_o),  32'd0);
    check_eq("rst_error", 32'(error_o), 32'd0);

    // Four-word copy through a one-wait-state RAM, started on the first edge after reset.
    for (int i = 0; i < 4; i++) begin
      mem[32'h4001_0000 + 32'(4 * i)]     = 32'h1111_1111 * 32'(i + 1);
      ref_mem[32'h4001_0000 + 32'(4 * i)] = 32'h1111_1111 * 32'(i + 1);
    end
    wait_fix = 1;
    rst = 1'b1;
    run_copy(32'h4001_0000, 32'h4001_0100, 4, -1, -1, 1'b0);
    check_eq("ack_count", 32'(acc_n), 32'd8);
    for (int i = 0; i < 4; i++)
      check_eq("dst_word", slv_rd(32'h4001_0100 + 32'(4 * i)), 32'h1111_1111 * 32'(i + 1));
    wait_fix = -1;

    run_copy(32'h4001_0000, 32'h4001_0400, 0, -1, -1, 1'b0);
    run_copy(32'h4001_0000, 32'h4001_0300, 3, 3, -1, 1'b0);
    run_copy(32'h4001_0002, 32'h4001_0200, 2, -1, 0, 1'b0);
    run_copy(32'h4003_0000, 32'h4003_0100, 2, -1, -1, 1'b1);
    run_copy(32'hFFFF_FFF9, 32'h4004_0000, 4, -1, 1, 1'b0);

    // Reset while the second word's write is on the bus.
    start_copy(32'h5000_0000, 32'h5000_0100, 4, -1, -1, 1'b0);
    @(negedge clk);
    start_i = 1'b0;
    cycles  = 0;
    while (!(bus.stb && bus.we && bus.adr == 32'h5000_0104) && cycles < 500) begin
      @(negedge clk);
      cycles++;
    end
    check_eq("reach_write2", bus.adr, 32'h5000_0104);
    rst = 1'b0;
    #1;
    check_eq("midrst_cyc",  32'(bus.cyc), 32'd0);
    check_eq("midrst_stb",  32'(bus.stb), 32'd0);
    check_eq("midrst_busy", 32'(busy_o),  32'd0);
    check_eq("midrst_adr",  bus.adr,      32'd0);
    repeat (3) @(negedge clk);
    check_eq("midrst_no_done", 32'(done_cnt), 32'd0);
    rst = 1'b1;
    run_copy(32'h4005_0000, 32'h4005_0100, 3, -1, -1, 1'b0);

    for (int t = 0; t < 30; t++) begin
      int len, ea, ra, lim;
      bit sil;
      len = int'($urandom_range(0, 6));
      sil = (len != 0) && ($urandom_range(0, 9) == 0);
      ea  = (len != 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2 * len - 1)) : -1;
      lim = (ea >= 0) ? ea : 2 * len;
      ra  = (lim > 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, lim - 1)) : -1;
      if (sil) begin
        ea = -1;
        ra = -1;
      end
      run_copy(32'h4002_0000 + 32'($urandom_range(0, 63) * 4) + 32'($urandom_range(0, 3)),
               32'h4002_0000 + 32'($urandom_range(0, 63) * 4) + 32'($urandom_range(0, 3)),
               len, ea, ra, sil);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_block_copier.md
WB_BLOCK_COPIER -- requirements
Module: wb_block_copier

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum wait cycles per bus access before the access is aborted.
REQ-002 Parameter LEN_W, default 12: width of the word-count input.
REQ-003 clk  in  1  single system clock; all state updates on its rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset (0 = reset).
REQ-005 start  in  1  one-cycle request to begin a copy; sampled only in IDLE.
REQ-006 src_adr  in  32  source byte address; bits [1:0] ignored and treated as 0.
REQ-007 dst_adr  in  32  destination byte address; bits [1:0] ignored and treated as 0.
REQ-008 len  in  LEN_W  number of 32-bit words to copy.
REQ-009 busy  out  1  high from the cycle after an accepted start until done.
REQ-010 done  out  1  one-cycle pulse when a copy completes or aborts.
REQ-011 error  out  1  sticky status of the last copy: 1 = aborted by wbm_err_i or timeout; cleared on the next accepted start.
REQ-012 wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone master cycle, strobe and write enable.
REQ-013 wbm_adr_o  out  32  word-aligned access address.
REQ-014 wbm_sel_o  out  4  byte selects; always 4'hF during accesses, 4'h0 otherwise.
REQ-015 wbm_dat_o  out  32  write data.
REQ-016 wbm_dat_i  in  32  read data.
REQ-017 wbm_ack_i, wbm_err_i, wbm_rty_i  in  1 each  slave termination signals.

Function
REQ-018 The FSM SHALL have states IDLE, READ, WRITE and FIN.
REQ-019 IDLE: start=1 with len!=0 SHALL latch src, dst and len, clear the word counter and error, and enter READ.
REQ-020 IDLE: start=1 with len=0 SHALL go to FIN with no bus activity.
REQ-021 READ: drive cyc=stb=1, we=0, adr=src+4*count.
REQ-022 READ: on ack, latch wbm_dat_i into the data buffer, deassert stb the next cycle and enter WRITE.
REQ-023 WRITE: drive cyc=stb=1, we=1, adr=dst+4*count, dat_o=buffer.
REQ-024 WRITE: on ack, increment count; enter FIN if count+1==len, else enter READ.
REQ-025 After every terminated access, stb SHALL be low for at least one cycle, so a slave that acks every other cycle is never double-acked.
REQ-026 rty_i SHALL drop stb for one cycle, then reissue the same access with the same address and data, and restart the timeout counter.
REQ-027 err_i SHALL set error and go to FIN; the remaining words are not transferred.
REQ-028 Priority when terminations coincide: err > ack > rty.
REQ-029 The timeout counter SHALL clear at the start of each access and increment each cycle stb is high without a termination.
REQ-030 When the timeout counter reaches TIMEOUT, the block SHALL set error and go to FIN.
REQ-031 Address arithmetic SHALL be modulo 2^32; wrap-around past 0xFFFFFFFC is permitted silently.
REQ-032 FIN: cyc=stb=0; done=1 for exactly one cycle; busy=0; return to IDLE.
REQ-033 start SHALL be ignored in READ, WRITE and FIN.
REQ-034 cyc SHALL remain high across the whole read-write pair of one word and drop only in FIN or IDLE.
REQ-035 Outputs SHALL be registered; wbm_dat_o SHALL hold the buffer value whenever we=1.

Reset
REQ-036 rst=0 SHALL immediately force IDLE and set cyc, stb, we, busy, done and error to 0, sel=4'h0, adr=0, dat_o=0, and counters to 0.
REQ-037 A reset asserted mid-transfer SHALL abort the transfer with no done pulse.
REQ-038 After rst returns to 1, the block SHALL accept start on the first rising edge.

Verification
REQ-039 With a 1-wait-state RAM model at 0x40010000, src=0x40010000, dst=0x40010100, len=4, src holding 0x11111111..0x44444444 -> dst holds the same 4 words; 8 acks; done pulses once; error=0.
REQ-040 len=0 -> done pulses 1-2 cycles after start; cyc never asserted.
REQ-041 err_i on the 2nd write of a len=3 copy -> error=1, done pulses, the 3rd word is never read, and cyc drops.
REQ-042 rty_i once on the first read -> the same address is reissued after a 1-cycle stb gap and the copy completes with error=0.
REQ-043 A slave that never responds, with TIMEOUT=8 -> stb high for 8 cycles, then error=1 and a done pulse.
REQ-044 rst pulled low during WRITE of word 2 -> cyc=stb=0 immediately and no done pulse; a new start after reset completes normally.
